// File: rtl/ds18b20_pkg.sv
// Shared constants and helpers for the DS18B20 scratchpad path.
// crc8_byte is also meant for the ROM-code reader.
package ds18b20_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_CONVERT = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam int unsigned FRAME_BYTES_DEF = 9;
    localparam logic [7:0]  CRC8_POLY       = 8'h8C;

    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Dallas/Maxim CRC8, LSB-first, one whole byte per call.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC8_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/bin8_to_dec3.sv
// Binary 0..255 to three BCD digits by repeated subtraction:
// hundreds first, then tens, one subtraction per cycle.
module bin8_to_dec3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       done,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_HUND = 2'd1;
    localparam logic [1:0] PH_TENS = 2'd2;

    logic [1:0] ph_q, ph_d;
    logic [7:0] rem_q;

    always_comb begin
        ph_d = ph_q;
        case (ph_q)
            PH_IDLE: if (start) ph_d = PH_HUND;
            PH_HUND: if (rem_q < 8'd100) ph_d = PH_TENS;
            PH_TENS: if (rem_q < 8'd10) ph_d = PH_IDLE;
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) ph_q <= PH_IDLE;
        else     ph_q <= ph_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            d2    <= '0;
            d1    <= '0;
            d0    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (ph_q)
                PH_IDLE: if (start) begin
                    rem_q <= value;
                    d2    <= '0;
                    d1    <= '0;
                    d0    <= '0;
                end
                PH_HUND: if (rem_q >= 8'd100) begin
                    rem_q <= rem_q - 8'd100;
                    d2    <= d2 + 4'd1;
                end
                PH_TENS: if (rem_q >= 8'd10) begin
                    rem_q <= rem_q - 8'd10;
                    d1    <= d1 + 4'd1;
                end else begin
                    d0   <= rem_q[3:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ds18b20_temp_formatter.sv
// Collects a DS18B20 scratchpad frame, checks its CRC and streams
// "T=+ddd.f\r\n" (or "T=ERR\r\n") to the UART transmitter.
module ds18b20_temp_formatter
    import ds18b20_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int unsigned TX_HOLDOFF  = 2,
    parameter logic [7:0]  PREFIX_CHAR = 8'h54
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        crc_err,
    output logic [15:0] temp_raw
);

    localparam int unsigned IDX_W  = $clog2(FRAME_BYTES + 1);
    localparam int unsigned HOLD_W = (TX_HOLDOFF < 1) ? 1 : $clog2(TX_HOLDOFF + 1);
    localparam int unsigned MSG_N  = 10;
    localparam int unsigned CHR_W  = 4;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        crc_q, b0_q, b1_q;
    logic [7:0]        msg_q [MSG_N];
    logic [CHR_W-1:0]  chr_q, last_q;
    logic [HOLD_W-1:0] hold_q;

    logic [15:0] raw_c;
    logic [11:0] mag_c;
    logic [3:0]  frac_c;
    logic        restart_c, accept_c, crc_ok_c, conv_start_c, fire_c;
    logic        conv_done;
    logic [3:0]  d2, d1, d0;

    // 0x8000 negates to itself; only mag[11:0] is kept, giving int 0.
    assign raw_c  = {b1_q, b0_q};
    assign mag_c  = raw_c[15] ? 12'(-raw_c) : raw_c[11:0];
    assign frac_c = 4'((8'(mag_c[3:0]) * 8'd10) >> 4);

    bin8_to_dec3 u_dec (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_c),
        .value (mag_c[11:4]),
        .done  (conv_done),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    always_comb begin
        state_d      = state_q;
        restart_c    = 1'b0;
        accept_c     = 1'b0;
        conv_start_c = 1'b0;
        fire_c       = 1'b0;
        crc_ok_c     = (crc_q == 8'h00);
        case (state_q)
            ST_IDLE: if (frame_start) begin
                restart_c = 1'b1;
                state_d   = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (frame_start) begin
                    restart_c = 1'b1;
                end else if (byte_valid) begin
                    accept_c = 1'b1;
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (crc_ok_c) begin
                    conv_start_c = 1'b1;
                    state_d      = ST_CONVERT;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_CONVERT: if (conv_done) state_d = ST_SEND;
            // tx_start term keeps pulses apart even with a zero holdoff
            ST_SEND: if (!tx_busy && hold_q == '0 && !tx_start) begin
                fire_c = 1'b1;
                if (chr_q == last_q) state_d = ST_DONE;
            end
            ST_DONE: if (!tx_busy && hold_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            crc_q    <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            temp_raw <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            crc_err  <= 1'b0;
            chr_q    <= '0;
            last_q   <= '0;
            hold_q   <= '0;
        end else begin
            tx_start <= fire_c;
            crc_err  <= (state_q == ST_CHECK) && !crc_ok_c;
            busy     <= (state_d != ST_IDLE) && (state_d != ST_COLLECT);
            if (restart_c) begin
                idx_q <= '0;
                crc_q <= '0;
            end else if (accept_c) begin
                if (idx_q == IDX_W'(0)) b0_q <= byte_in;
                if (idx_q == IDX_W'(1)) b1_q <= byte_in;
                crc_q <= crc8_byte(crc_q, byte_in);
                idx_q <= idx_q + IDX_W'(1);
            end
            if (state_q == ST_CHECK) begin
                chr_q  <= '0;
                last_q <= crc_ok_c ? CHR_W'(MSG_N - 1) : CHR_W'(6);
                if (crc_ok_c) temp_raw <= raw_c;
            end
            if (fire_c) begin
                tx_data <= msg_q[chr_q];
                chr_q   <= chr_q + CHR_W'(1);
                hold_q  <= HOLD_W'(TX_HOLDOFF);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    // Line buffer: error text on a bad CRC, reading once digits are ready.
    always_ff @(posedge clk) begin
        if (state_q == ST_CHECK && !crc_ok_c) begin
            msg_q[0] <= PREFIX_CHAR;
            msg_q[1] <= ASCII_EQ;
            msg_q[2] <= ASCII_E;
            msg_q[3] <= ASCII_R;
            msg_q[4] <= ASCII_R;
            msg_q[5] <= ASCII_CR;
            msg_q[6] <= ASCII_LF;
        end else if (state_q == ST_CONVERT && conv_done) begin
            msg_q[0] <= PREFIX_CHAR;
            msg_q[1] <= ASCII_EQ;
            msg_q[2] <= raw_c[15] ? ASCII_MINUS : ASCII_PLUS;
            msg_q[3] <= ASCII_ZERO + 8'(d2);
            msg_q[4] <= ASCII_ZERO + 8'(d1);
            msg_q[5] <= ASCII_ZERO + 8'(d0);
            msg_q[6] <= ASCII_DOT;
            msg_q[7] <= ASCII_ZERO + 8'(frac_c);
            msg_q[8] <= ASCII_CR;
            msg_q[9] <= ASCII_LF;
        end
    end

endmodule

// File: tb/tb_ds18b20_temp_formatter.sv
// Directed bench for ds18b20_temp_formatter with a simple UART busy model.
module tb_ds18b20_temp_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        tx_busy, tx_start, busy, crc_err;
    logic [7:0]  tx_data;
    logic [15:0] temp_raw;

    int total = 0;
    int bad = 0;
    int busy_len = 3;
    int bcnt = 0;
    int viol = 0;
    int err_pulses = 0;
    int e0 = 0;
    int n = 0;
    logic prev_start = 1'b0;
    logic [7:0] rxq [$];
    logic [7:0] fr [9];

    ds18b20_temp_formatter dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .crc_err     (crc_err),
        .temp_raw    (temp_raw)
    );

    always #50 clk = ~clk;

    // UART model: busy rises one cycle after tx_start and lasts busy_len cycles.
    assign tx_busy = (bcnt != 0);
    always @(posedge clk) begin
        if (tx_start) begin
            if (tx_busy || prev_start) viol <= viol + 1;
            rxq.push_back(tx_data);
            bcnt <= busy_len;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
        prev_start <= tx_start;
        if (crc_err) err_pulses <= err_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input string exp);
        chk({tag, "_len"}, 32'(rxq.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            chk($sformatf("%s_chr%0d", tag, i),
                (i < rxq.size()) ? 32'(rxq[i]) : 32'hDEAD, 32'(exp[i]));
        end
        rxq.delete();
    endtask

    // Frame with given reading; CRC8 computed bit-serially in shift-register form.
    task automatic build_frame(input logic [15:0] raw, input logic corrupt);
        logic [7:0] c;
        logic       inb;
        fr[0] = raw[7:0];
        fr[1] = raw[15:8];
        fr[2] = 8'h4B; fr[3] = 8'h46; fr[4] = 8'h7F;
        fr[5] = 8'hFF; fr[6] = 8'h0C; fr[7] = 8'h10;
        c = 8'h00;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                inb = fr[k][j] ^ c[0];
                c   = {inb, c[7:5], c[4] ^ inb, c[3] ^ inb, c[2:1]};
            end
        end
        fr[8] = corrupt ? (c ^ 8'h01) : c;
    endtask

    task automatic put_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bytes(input int cnt);
        for (int i = 0; i < cnt; i++) put_byte(fr[i]);
    endtask

    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!busy && w < 50) begin tick(); w++; end
        while (busy && w < 20000) begin tick(); w++; end
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] raw, input logic corrupt,
                             input logic [15:0] exp_temp, input string exp_line);
        build_frame(raw, corrupt);
        pulse_start();
        send_bytes(9);
        wait_done(tag);
        chk({tag, "_temp"}, 32'(temp_raw), 32'(exp_temp));
        chk_line(tag, exp_line);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crc_err", 32'(crc_err), 32'd0);
        chk("rst_temp", 32'(temp_raw), 32'd0);

        // byte_valid in IDLE is ignored
        put_byte(8'h77);
        chk("idle_busy", 32'(busy), 32'd0);

        e0 = err_pulses;
        run_frame("pos85", 16'h0550, 1'b0, 16'h0550, "T=+085.0\015\012");
        chk("pos85_err", 32'(err_pulses - e0), 32'd0);
        run_frame("neg10", 16'hFF5E, 1'b0, 16'hFF5E, "T=-010.1\015\012");
        run_frame("max", 16'h0FFF, 1'b0, 16'h0FFF, "T=+255.9\015\012");
        run_frame("m8000", 16'h8000, 1'b0, 16'h8000, "T=-000.0\015\012");
        run_frame("zero", 16'h0000, 1'b0, 16'h0000, "T=+000.0\015\012");

        // bad CRC: last byte 0x1D, temp_raw keeps the previous good reading
        e0 = err_pulses;
        run_frame("badcrc", 16'h0550, 1'b1, 16'h0000, "T=ERR\015\012");
        chk("badcrc_pulses", 32'(err_pulses - e0), 32'd1);

        // slow transmitter
        busy_len = 1000;
        run_frame("slow", 16'h0550, 1'b0, 16'h0550, "T=+085.0\015\012");
        busy_len = 3;
        chk("tx_protocol", 32'(viol), 32'd0);

        // restart after 4 bytes; simultaneous frame_start+byte_valid drops the byte
        build_frame(16'h0550, 1'b0);
        pulse_start();
        send_bytes(4);
        frame_start = 1'b1;
        byte_valid  = 1'b1;
        byte_in     = 8'hAA;
        tick();
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        build_frame(16'h0191, 1'b0);
        send_bytes(9);
        n = 0;
        while (rxq.size() == 0 && n < 300) begin tick(); n++; end
        pulse_start();
        put_byte(8'h55);
        wait_done("restart");
        chk("restart_temp", 32'(temp_raw), 32'h0191);
        chk_line("restart", "T=+025.0\015\012");
        repeat (30) tick();
        chk("ignored_busy", 32'(busy), 32'd0);
        chk("ignored_chars", 32'(rxq.size()), 32'd0);

        // reset mid-send after three characters
        build_frame(16'h0550, 1'b0);
        pulse_start();
        send_bytes(9);
        n = 0;
        while (rxq.size() < 3 && n < 500) begin tick(); n++; end
        chk("midrst_chars", 32'(rxq.size()), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_temp", 32'(temp_raw), 32'd0);
        n = 0;
        while (tx_busy && n < 100) begin tick(); n++; end
        repeat (10) tick();
        chk("midrst_no_resume", 32'(rxq.size()), 32'd3);
        rxq.delete();
        run_frame("after_rst", 16'h0550, 1'b0, 16'h0550, "T=+085.0\015\012");
        chk("tx_protocol_end", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ds18b20_temp_formatter.md
Name: ds18b20_temp_formatter

Overview:
- Downstream consumer of the 1-Wire scratchpad reader; sits between the 1-Wire read sequencer and the existing async UART transmitter.
- Accepts the 9 scratchpad bytes one per strobe and checks the Dallas CRC8.
- Converts the signed 1/16 °C reading into a fixed-width ASCII line and streams it byte-by-byte to the UART using its start/busy handshake.
- Replaces the raw-byte dump currently sent to the UART.

Parameters:
- FRAME_BYTES, 9, number of bytes per frame; the CRC byte is last, the temperature LSB/MSB are bytes 0/1.
- TX_HOLDOFF, 2, cycles to wait after a tx_start pulse before sampling tx_busy again (covers the transmitter's busy-rise latency).
- PREFIX_CHAR, 8'h54 ('T'), first character of every line.

Ports:
- clk  in  1  system clock (10 MHz board clock).
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; clears the byte index and CRC, and starts a new frame.
- byte_valid  in  1  one-cycle strobe; byte_in holds a scratchpad byte.
- byte_in  in  8  scratchpad byte, in index order 0..8.
- tx_busy  in  1  busy output of the UART transmitter.
- tx_start  out  1  one-cycle pulse to the UART transmitter.
- tx_data  out  8  character presented to the transmitter; stable from the tx_start cycle until the next tx_start.
- busy  out  1  high outside IDLE and COLLECT.
- crc_err  out  1  one-cycle pulse when a completed frame fails CRC.
- temp_raw  out  16  last CRC-good reading, {byte1, byte0}.

Behaviour:
- Reset values: tx_start=0, tx_data=0, busy=0, crc_err=0, temp_raw=0; state IDLE, index 0, CRC 0.
  - A reset arriving mid-conversion or mid-send aborts immediately. No partial line is resumed.
- States: IDLE, COLLECT, CHECK, CONVERT, SEND, DONE.
- IDLE:
  - frame_start -> COLLECT.
  - byte_valid in IDLE is ignored.
- COLLECT, per accepted byte_valid:
  - Store the byte at the current index.
  - Update the CRC with Dallas CRC8: init 0x00, LSB-first, reflected polynomial 0x8C, one full byte per cycle (8 unrolled steps).
  - Increment the index.
  - When the FRAME_BYTES-th byte is accepted, go to CHECK on the next cycle.
- COLLECT, frame_start: restarts the frame (index 0, CRC 0). If frame_start and byte_valid occur in the same cycle, frame_start wins and the byte is dropped.
- CHECK (1 cycle):
  - CRC residue 0: latch temp_raw and go to CONVERT.
  - Otherwise: pulse crc_err, load the error message, go to SEND.
- CONVERT:
  - sign = raw[15]; mag = sign ? -raw : raw (16-bit two's complement).
  - int = mag[11:4] (0..255); frac digit = (mag[3:0]*10) >> 4, i.e. 0..9, truncated.
  - Decimal digits come from sequential subtraction: count the 100s, then the 10s, one subtraction per cycle. Worst case ≤ 12 cycles, then go to SEND.
- Message formats:
  - Good frame, 10 chars: PREFIX '=' sign('+' or '-') d2 d1 d0 '.' f CR LF. Zero reads as "+000.0".
  - Bad CRC, 7 chars: PREFIX '=' 'E' 'R' 'R' CR LF.
- SEND:
  - Drive tx_data and pulse tx_start only when tx_busy=0 and the holdoff counter is 0.
  - Reload the holdoff counter with TX_HOLDOFF after each pulse.
  - tx_start is never high two consecutive cycles.
  - After the last character, go to DONE.
- DONE: wait until tx_busy=0, then go to IDLE.
- While busy=1, frame_start and byte_valid are ignored. The upstream sequencer must not start a new frame until busy falls.
- Bytes received after FRAME_BYTES (before CHECK) cannot occur, because the index saturates and COLLECT exits.
- Arithmetic: all widths are unsigned except the sign extraction. Negation of 0x8000 gives mag 0x8000, and int then uses mag[11:4]=0x00; this is documented, not trapped.

Decomposition:
- Shared package (ds18b20_pkg):
  - state enum;
  - CRC8 polynomial constant 0x8C;
  - ASCII constants ('=', '+', '-', '.', 'E', 'R', CR, LF, '0');
  - FRAME_BYTES default;
  - a crc8_byte update function, reused later by the ROM-code reader.
- One sub-module: bin8_to_dec3.
  - Sequential subtract converter: start/done handshake, 8-bit in, three 4-bit digits out.

Test Plan:
- Bytes 50 05 4B 46 7F FF 0C 10 1C after frame_start -> crc_err stays 0, temp_raw=0x0550, UART stream "T=+085.0\r\n" (10 tx_start pulses).
- Raw 0xFF5E (-10.125 °C) with bench-computed valid CRC -> "T=-010.1\r\n".
- Same as the first scenario with the last byte 0x1D -> single crc_err pulse, temp_raw unchanged, stream "T=ERR\r\n".
- tx_busy held high for 1000 cycles after each start -> no tx_start while busy, no duplicated or lost characters, line intact.
- frame_start after 4 bytes, then a full valid frame -> only the second frame is reported. byte_valid and frame_start asserted during SEND are ignored.
- rst asserted mid-SEND (after 3 characters) -> tx_start low next cycle, busy=0, temp_raw=0. The next valid frame produces a complete, correct line.
